// File: rtl/ifu_sram_fetch.sv
// rtl/ifu_sram_fetch.sv - single-transaction instruction fetch over an SRAM-style port with fault reporting
module ifu_sram_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIMEOUT    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  busy,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] snpc,
    output logic [1:0]            fault
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_MIS  = 2'd1;
    localparam logic [1:0] FAULT_BUS  = 2'd2;
    localparam logic [1:0] FAULT_TO   = 2'd3;
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_req_valid;
    logic                  r_m_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_pc_out;
    logic [ADDR_WIDTH-1:0] r_snpc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [1:0]            r_fault;

    logic w_accept;
    logic w_misaligned;

    // A new fetch is taken from IDLE, or from HOLD in the same cycle the bundle is consumed.
    assign w_accept     = fetch_en && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && m_ready));
    assign w_misaligned = |pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_req_valid <= 1'b0;
            r_m_valid   <= 1'b0;
            r_addr      <= '0;
            r_pc_out    <= '0;
            r_snpc      <= ADDR_WIDTH'(4);
            r_inst      <= RESET_INST;
            r_fault     <= FAULT_NONE;
        end else if (w_accept) begin
            r_addr   <= pc;
            r_pc_out <= pc;
            r_snpc   <= pc + ADDR_WIDTH'(4);
            r_inst   <= RESET_INST;
            if (w_misaligned) begin
                r_state     <= ST_HOLD;
                r_fault     <= FAULT_MIS;
                r_m_valid   <= 1'b1;
                r_req_valid <= 1'b0;
            end else begin
                r_state     <= ST_REQ;
                r_fault     <= FAULT_NONE;
                r_m_valid   <= 1'b0;
                r_req_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_REQ: begin
                    if (imem_req_ready) begin
                        r_state     <= ST_WAIT;
                        r_req_valid <= 1'b0;
                        r_cnt       <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state   <= ST_HOLD;
                        r_m_valid <= 1'b1;
                        r_inst    <= imem_rsp_err ? RESET_INST : imem_rsp_data;
                        r_fault   <= imem_rsp_err ? FAULT_BUS : FAULT_NONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= ST_HOLD;
                        r_m_valid <= 1'b1;
                        r_fault   <= FAULT_TO;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        r_state   <= ST_IDLE;
                        r_m_valid <= 1'b0;
                        r_inst    <= RESET_INST;
                        r_fault   <= FAULT_NONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign imem_req_valid = r_req_valid;
    assign imem_addr      = r_addr;
    assign m_valid        = r_m_valid;
    assign inst           = r_inst;
    assign pc_out         = r_pc_out;
    assign snpc           = r_snpc;
    assign fault          = r_fault;

endmodule
